// File: rtl/seg_pkg.sv
// Shared 7-segment definitions: segment vector type, the all-off pattern and
// the active-low hex glyph table (bit 6 = A ... bit 0 = G).
package seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_OFF = 7'b1111111;

  localparam seg_t HEX_TABLE [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex-to-segment decoder, active-low glyphs from seg_pkg.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_TABLE[hex_i];

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed N-digit 7-segment scanner with shadow/active data copies,
// leading-zero suppression, anode dead time and a frame-done strobe.
module seven_seg_scanner
  import seg_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   digits_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_in,
  input  logic                  lz_suppress,
  output logic [6:0]            seven,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(DIGITS);

  localparam logic [6:0]        SEVEN_OFF = SEG_ACTIVE_LOW ? SEG_OFF : ~SEG_OFF;
  localparam logic              DP_ON     = SEG_ACTIVE_LOW ? 1'b0 : 1'b1;
  localparam logic              DP_OFF    = ~DP_ON;
  localparam logic [DIGITS-1:0] AN_OFF    = AN_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [PW-1:0]       presc_q, presc_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] sh_digits_q, act_digits_q, act_digits_d;
  logic [DIGITS-1:0]   sh_dp_q, act_dp_q, act_dp_d;
  logic [DIGITS-1:0]   sh_blank_q, act_blank_q, act_blank_d;
  logic                sh_lz_q, act_lz_q, act_lz_d;
  logic [6:0]          seven_q, seven_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                frame_q, frame_d;

  logic                wrap_s;
  logic [DIGITS-1:0]   sup_s;
  logic                zero_run_s;
  logic [3:0]          digit_sel_s;
  logic [6:0]          dec_s;

  // Shadow copy: free to change any cycle, never drives the display directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_digits_q <= {(4*DIGITS){1'b0}};
      sh_dp_q     <= {DIGITS{1'b0}};
      sh_blank_q  <= {DIGITS{1'b0}};
      sh_lz_q     <= 1'b0;
    end else if (load) begin
      sh_digits_q <= digits_in;
      sh_dp_q     <= dp_in;
      sh_blank_q  <= blank_in;
      sh_lz_q     <= lz_suppress;
    end
  end

  // Prescaler, slot index and active copy; outputs below use these next values.
  always_comb begin
    wrap_s       = (presc_q == PW'(REFRESH_DIV - 1));
    presc_d      = presc_q + PW'(1);
    idx_d        = idx_q;
    act_digits_d = act_digits_q;
    act_dp_d     = act_dp_q;
    act_blank_d  = act_blank_q;
    act_lz_d     = act_lz_q;
    frame_d      = 1'b0;
    if (wrap_s) begin
      presc_d      = {PW{1'b0}};
      idx_d        = (idx_q == IW'(DIGITS - 1)) ? {IW{1'b0}} : idx_q + IW'(1);
      frame_d      = (idx_q == IW'(DIGITS - 1));
      act_digits_d = sh_digits_q;
      act_dp_d     = sh_dp_q;
      act_blank_d  = sh_blank_q;
      act_lz_d     = sh_lz_q;
    end else begin
      frame_d = 1'b0;
    end
  end

  // A digit is suppressed while it and everything above it is zero; digit 0 never is.
  always_comb begin
    sup_s      = {DIGITS{1'b0}};
    zero_run_s = act_lz_d;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run_s = zero_run_s && (act_digits_d[4*i +: 4] == 4'h0);
      sup_s[i]   = zero_run_s;
    end
  end

  assign digit_sel_s = act_digits_d[4*idx_d +: 4];

  seg_hex_decode u_dec (
    .hex_i (digit_sel_s),
    .seg_o (dec_s)
  );

  // Output stage: segments settle with the index, anodes held off while prescaler is 0.
  always_comb begin
    seven_d = SEG_ACTIVE_LOW ? dec_s : ~dec_s;
    dp_d    = act_dp_d[idx_d] ? DP_ON : DP_OFF;
    an_d    = AN_OFF;
    if (act_blank_d[idx_d]) begin
      seven_d = SEVEN_OFF;
      dp_d    = DP_OFF;
    end else if (sup_s[idx_d]) begin
      seven_d = SEVEN_OFF;
    end else begin
      seven_d = SEG_ACTIVE_LOW ? dec_s : ~dec_s;
    end
    if (presc_d != {PW{1'b0}}) begin
      an_d = AN_ACTIVE_LOW ? ~({{(DIGITS-1){1'b0}}, 1'b1} << idx_d)
                           :  ({{(DIGITS-1){1'b0}}, 1'b1} << idx_d);
    end else begin
      an_d = AN_OFF;
    end
  end

  // State and registered output update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q      <= {PW{1'b0}};
      idx_q        <= {IW{1'b0}};
      act_digits_q <= {(4*DIGITS){1'b0}};
      act_dp_q     <= {DIGITS{1'b0}};
      act_blank_q  <= {DIGITS{1'b0}};
      act_lz_q     <= 1'b0;
      seven_q      <= SEVEN_OFF;
      dp_q         <= DP_OFF;
      an_q         <= AN_OFF;
      frame_q      <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      act_digits_q <= act_digits_d;
      act_dp_q     <= act_dp_d;
      act_blank_q  <= act_blank_d;
      act_lz_q     <= act_lz_d;
      seven_q      <= seven_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_q      <= frame_d;
    end
  end

  assign seven      = seven_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = frame_q;

endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
Time-multiplexed N-digit 7-segment display driver. Captures a packed hex word plus per-digit decimal-point and blank masks, then cycles one digit at a time, driving shared segment lines and one-hot anode enables at a parametrised refresh rate. Adds leading-zero suppression, anti-ghost dead time and a frame-done strobe. Sits between the clock/counter datapath and the board's display pins.

Parameters:
DIGITS, 4, number of digits/anodes (2..8)
REFRESH_DIV, 50000, clk cycles per digit slot (>=2)
SEG_ACTIVE_LOW, 1, 1 = segment lit by driving 0
AN_ACTIVE_LOW, 1, 1 = anode enabled by driving 0

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
load  in  1  capture strobe for the data inputs
digits_in  in  4*DIGITS  packed hex digits; [3:0] = digit 0 = least significant digit (LSD)
dp_in  in  DIGITS  decimal point per digit, 1 = lit
blank_in  in  DIGITS  force digit dark, 1 = blank
lz_suppress  in  1  enable leading-zero suppression
seven  out  7  segments ABCDEFG, bit 6 = A, bit 0 = G
dp  out  1  decimal point segment
an  out  DIGITS  anode enables, one-hot when active
frame_done  out  1  one-cycle pulse after the last digit slot ends

Behaviour:
- Reset (async assert, sync release): all outputs inactive: seven all off, dp off, an all off, frame_done=0. Prescaler=0, slot index=0, shadow and active registers cleared (display shows 0s once running).
- Shadow register: on any clk edge with load=1, capture digits_in, dp_in, blank_in, lz_suppress. lz_suppress is static and sampled only via load.
- Active register: copied from shadow at every slot boundary (prescaler wrap). A digit never changes mid-slot. A load in the same cycle as a boundary reaches the active copy at the next boundary.
- Prescaler: counts 0..REFRESH_DIV-1 and wraps. On wrap, slot index increments; DIGITS-1 wraps to 0.
- frame_done: high for exactly one cycle, in the cycle after index wraps DIGITS-1 -> 0.
- Dead time: while prescaler==0, an is all inactive (anti-ghosting). For prescaler>=1, an selects the current index only.
- Outputs are registered. seven/dp update in the same cycle the index changes, so their value is already stable before the anode turns on.
- Decode, active-low form (inverted when SEG_ACTIVE_LOW=0):
  0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111,
  8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
- Blank digit: seven all off and dp off. The anode still follows the scan, so brightness stays uniform.
- Leading-zero suppression (lz_suppress=1): working from the MSD downward, each 0 digit is blanked until the first nonzero digit. Digit 0 is never suppressed. dp_in of a suppressed digit is still honoured. blank_in overrides everything.
- Reset mid-scan returns immediately to the reset state, and the scan restarts at digit 0.

Decomposition:
- Shared package seg_pkg:
  - SEG_OFF constant
  - 16-entry hex pattern table (active-low)
  - seg_t typedef (7-bit)
- One sub-module, seg_hex_decode: combinational, 4-bit to seg_t, using the package table. It replaces the older per-design decoders.
- The scanner instantiates one seg_hex_decode on the muxed active digit.

Test Plan:
- Reset: assert rst mid-slot -> seven=1111111, dp=1, an=1111, frame_done=0 in the same cycle (async), before any clk edge.
- Scan: DIGITS=4, REFRESH_DIV=4, load digits_in=16'h1234, dp_in=0 -> an steps 1110,1101,1011,0111, each slot preceded by one all-off cycle. seven = 4(1001100), 3, 2, 1 on digits 0..3. frame_done pulses once every 16 cycles.
- Full decode: sweep each hex value A..F on digit 0 -> the exact patterns above. Repeat with SEG_ACTIVE_LOW=0 -> bitwise inverted patterns.
- LZ suppression: digits_in=16'h0050, lz_suppress=1 -> digits 3,2 dark, digit 1 shows 5, digit 0 shows 0. digits_in=16'h0000 -> only digit 0 lit, showing 0.
- Blank/dp: blank_in=4'b0100, dp_in=4'b0101 -> digit 2 fully dark including its dp. Digit 0 dp=0 (lit, active-low); other dp off.
- Tear-free load: pulse load with 16'hFFFF two cycles into the digit-1 slot -> digit 1 keeps its old value until the slot boundary, and the new values apply from digit 2 onward.
